// File: rtl/rng_byte_stream_gen.sv
// Seedable Galois-LFSR random word source with a small output FIFO and a
// valid/ready stream. Each generated word advances the LFSR OUT_W steps.
module rng_byte_stream_gen #(
  parameter int                LFSR_W       = 16,
  parameter int                OUT_W        = 8,
  parameter logic [LFSR_W-1:0] TAPS         = 16'hB400,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1,
  parameter int                FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          seed_load,
  input  logic [LFSR_W-1:0]             seed,
  input  logic                          enable,
  input  logic                          rnd_ready,
  output logic                          rnd_valid,
  output logic [OUT_W-1:0]              rnd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [LFSR_W-1:0]             lfsr_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {RUN, RESEED} state_t;

  state_t             state;
  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  next_lfsr;
  logic [OUT_W-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [LW-1:0]      level;
  logic               pop;
  logic               push;

  // OUT_W Galois steps unrolled into one combinational advance
  always_comb begin
    next_lfsr = lfsr;
    for (int i = 0; i < OUT_W; i++)
      next_lfsr = next_lfsr[0] ? ((next_lfsr >> 1) ^ TAPS) : (next_lfsr >> 1);
  end

  // seed_load overrides everything: no pop, no push that cycle
  assign rnd_valid = (level != '0);
  assign pop       = rnd_valid && rnd_ready && !seed_load;
  assign push      = !seed_load && (state == RUN) && enable &&
                     ((level < LW'(FIFO_DEPTH)) || pop);

  // Control FSM and LFSR; LFSR only moves when a word is pushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      lfsr  <= DEFAULT_SEED;
    end else if (seed_load) begin
      state <= RESEED;
      lfsr  <= (seed == '0) ? DEFAULT_SEED : seed;
    end else begin
      state <= RUN;
      if (push) lfsr <= next_lfsr;
    end
  end

  // Output FIFO: storage, wrapping pointers and occupancy; flushed on reseed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (seed_load) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= next_lfsr[OUT_W-1:0];
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign rnd_data   = mem[rd_ptr];
  assign fifo_level = level;
  assign lfsr_state = lfsr;

endmodule

// File: tb/tb_rng_byte_stream_gen.sv
// Scoreboard bench: a reference LFSR/queue tracks expected buffered words,
// popped entries are compared against rnd_data when the consumer accepts.
module tb_rng_byte_stream_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [15:0] seed;
  logic        enable;
  logic        rnd_ready;
  logic        rnd_valid;
  logic [7:0]  rnd_data;
  logic [2:0]  fifo_level;
  logic [15:0] lfsr_state;

  rng_byte_stream_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load),
    .seed       (seed),
    .enable     (enable),
    .rnd_ready  (rnd_ready),
    .rnd_valid  (rnd_valid),
    .rnd_data   (rnd_data),
    .fifo_level (fifo_level),
    .lfsr_state (lfsr_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  q[$];
  logic [15:0] m_lfsr;
  logic        m_reseed;
  logic        hold_prev;
  logic [7:0]  hold_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] gal8(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      if (t[0]) t = (t >> 1) ^ 16'hB400;
      else      t = t >> 1;
    end
    return t;
  endfunction

  task automatic model_reset();
    q.delete();
    m_lfsr    = 16'hACE1;
    m_reseed  = 1'b0;
    hold_prev = 1'b0;
  endtask

  // One clock: drive inputs, check outputs vs model, advance model, step edge
  task automatic cyc(input logic se, input logic [15:0] sd, input logic en, input logic rdy);
    logic pop_m, push_m;
    logic [7:0] e;
    seed_load = se; seed = sd; enable = en; rnd_ready = rdy;
    chk("valid", rnd_valid, q.size() != 0);
    chk("level", fifo_level, q.size());
    chk("lfsr",  lfsr_state, m_lfsr);
    if (hold_prev) chk("stable", rnd_data, hold_data);
    hold_prev = rnd_valid && !rdy && !se;
    hold_data = rnd_data;
    if (se) begin
      q.delete();
      m_lfsr   = (sd == 16'h0) ? 16'hACE1 : sd;
      m_reseed = 1'b1;
    end else begin
      pop_m  = (q.size() != 0) && rdy;
      push_m = !m_reseed && en && (q.size() < 4 || pop_m);
      if (pop_m) begin
        e = q.pop_front();
        chk("data", rnd_data, e);
      end
      if (push_m) begin
        m_lfsr = gal8(m_lfsr);
        q.push_back(m_lfsr[7:0]);
      end
      m_reseed = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; seed_load = 1'b0; seed = '0; enable = 1'b0; rnd_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_valid", rnd_valid, 0);
    chk("rst_data",  rnd_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_lfsr",  lfsr_state, 16'hACE1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill from reset: first word and state are known constants
    cyc(0, 0, 1, 0);
    chk("first_word", rnd_data, 8'hC4);
    chk("first_lfsr", lfsr_state, 16'hC2C4);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
    chk("full_level", fifo_level, 4);

    // Zero seed falls back to the default seed
    cyc(1, 16'h0000, 1, 0);
    chk("seed0_valid", rnd_valid, 0);
    cyc(0, 0, 1, 0);
    chk("reseed_gap", rnd_valid, 0);
    cyc(0, 0, 1, 0);
    chk("seed0_word", rnd_data, 8'hC4);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);

    // Full FIFO streaming at one word per cycle
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 1, 1);
      chk("stream_level", fifo_level, 4);
    end

    // Reseed at level 3 with a pending pop
    cyc(0, 0, 0, 1);
    chk("lvl3", fifo_level, 3);
    cyc(1, 16'h1234, 1, 1);
    chk("rs_valid", rnd_valid, 0);
    chk("rs_level", fifo_level, 0);
    cyc(0, 0, 1, 1);
    chk("rs_e1_valid", rnd_valid, 0);
    cyc(0, 0, 1, 1);
    chk("rs_e2_valid", rnd_valid, 1);
    chk("rs_word", rnd_data, gal8(16'h1234) & 16'h00FF);

    // Random traffic with rare reseeds
    for (int i = 0; i < 10000; i++) begin
      logic se;
      logic [15:0] sd;
      se = ($urandom_range(0, 499) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      cyc(se, sd, 1'($urandom), 1'($urandom));
    end

    // Asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1);
    #2 rst_n = 1'b0;
    enable = 1'b0; rnd_ready = 1'b0; seed_load = 1'b0;
    #1;
    chk("arst_valid", rnd_valid, 0);
    chk("arst_data",  rnd_data, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_lfsr",  lfsr_state, 16'hACE1);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(0, 0, 1, 0);
    chk("arst_word", rnd_data, 8'hC4);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
